mem_arbiter: RTL and testbench

- Shares the single-port `memory` block between an instruction-fetch requester (I) and a load/store requester (D).
- Grants at most one access per cycle and drives the memory's address, mask, write flag and write data.
- Routes the one-cycle-late read data back to whichever requester issued the read.
- Counts arbitration conflicts for performance debug.

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory: instruction fetch (I)
// and load/store (D) share one access per cycle, read data returns one cycle later.
module mem_arbiter #(
    parameter int N         = 32,
    parameter int M         = 10,
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic [M+1:0]     i_addr,
    output logic             i_ready,
    output logic             i_rvalid,
    output logic [N-1:0]     i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [M+1:0]     d_addr,
    input  logic [N-1:0]     d_mask,
    input  logic [N-1:0]     d_wdata,
    output logic             d_ready,
    output logic             d_rvalid,
    output logic [N-1:0]     d_rdata,
    output logic [M+1:0]     mem_address,
    output logic [N-1:0]     mem_mask,
    output logic             mem_wf,
    output logic [N-1:0]     mem_w,
    input  logic [N-1:0]     mem_v,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {SIDE_I, SIDE_D} side_t;

    side_t          last_grant;
    logic           gnt_i, gnt_d;
    logic           rv_i, rv_d;
    logic [N-1:0]   hold_i, hold_d;

    // Grants are gated by rst_n so nothing reaches memory while reset is low.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst_n) begin
            if (i_req && d_req) begin
                if (PRIO_MODE == 1 || last_grant == SIDE_I) gnt_d = 1'b1;
                else                                        gnt_i = 1'b1;
            end else if (i_req) begin
                gnt_i = 1'b1;
            end else if (d_req) begin
                gnt_d = 1'b1;
            end
        end
    end

    assign i_ready = gnt_i;
    assign d_ready = gnt_d;

    always_comb begin
        mem_address = '0;
        mem_mask    = '0;
        mem_wf      = 1'b0;
        mem_w       = '0;
        if (gnt_i) begin
            mem_address = i_addr;
        end else if (gnt_d) begin
            mem_address = d_addr;
            mem_wf      = d_we;
            mem_mask    = d_mask;
            mem_w       = d_wdata;
        end
    end

    // rv_i / rv_d together form the response-owner register (neither set = NONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_i         <= 1'b0;
            rv_d         <= 1'b0;
            last_grant   <= SIDE_D;
            conflict_cnt <= '0;
            hold_i       <= '0;
            hold_d       <= '0;
        end else begin
            rv_i <= gnt_i;
            rv_d <= gnt_d && !d_we;
            if (gnt_i)      last_grant <= SIDE_I;
            else if (gnt_d) last_grant <= SIDE_D;
            if (i_req && d_req && conflict_cnt != {CNT_W{1'b1}})
                conflict_cnt <= conflict_cnt + 1'b1;
            if (rv_i) hold_i <= mem_v;
            if (rv_d) hold_d <= mem_v;
        end
    end

    assign i_rvalid = rv_i;
    assign d_rvalid = rv_d;
    // Owner sees memory data live; the other side keeps its last response.
    assign i_rdata  = rv_i ? mem_v : hold_i;
    assign d_rdata  = rv_d ? mem_v : hold_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with a data scoreboard,
// plus a fixed-priority instance with a 4-bit counter driven by the same stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [11:0] i_addr, d_addr;
    logic [31:0] d_mask, d_wdata;

    logic        i_ready, i_rvalid, d_ready, d_rvalid, mem_wf;
    logic [31:0] i_rdata, d_rdata, mem_mask, mem_w, mem_v;
    logic [11:0] mem_address;
    logic [15:0] conflict_cnt;

    logic        i_ready_p, i_rvalid_p, d_ready_p, d_rvalid_p, mem_wf_p;
    logic [31:0] i_rdata_p, d_rdata_p, mem_mask_p, mem_w_p, mem_v_p;
    logic [11:0] mem_address_p;
    logic [3:0]  conflict_cnt_p;

    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.N(32), .M(10), .PRIO_MODE(0), .CNT_W(16)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_mask(d_mask), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_mask(mem_mask), .mem_wf(mem_wf), .mem_w(mem_w),
        .mem_v(mem_v), .conflict_cnt(conflict_cnt)
    );

    mem_arbiter #(.N(32), .M(10), .PRIO_MODE(1), .CNT_W(4)) dut_pr (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready_p), .i_rvalid(i_rvalid_p), .i_rdata(i_rdata_p),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_mask(d_mask), .d_wdata(d_wdata),
        .d_ready(d_ready_p), .d_rvalid(d_rvalid_p), .d_rdata(d_rdata_p),
        .mem_address(mem_address_p), .mem_mask(mem_mask_p), .mem_wf(mem_wf_p), .mem_w(mem_w_p),
        .mem_v(mem_v_p), .conflict_cnt(conflict_cnt_p)
    );

    // Memory models: masked write, registered read; contents reloaded while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem0[0] <= 32'hcafebabe; mem0[1] <= 32'h11111111;
            mem0[2] <= 32'h22222222; mem0[1020] <= 32'h0ff00ff0;
        end else if (mem_wf) begin
            mem0[mem_address[11:2]] <= (mem0[mem_address[11:2]] & ~mem_mask) | (mem_w & mem_mask);
        end
        mem_v <= mem0[mem_address[11:2]];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            mem1[0] <= 32'hcafebabe; mem1[1] <= 32'h11111111;
            mem1[2] <= 32'h22222222; mem1[1020] <= 32'h0ff00ff0;
        end else if (mem_wf_p) begin
            mem1[mem_address_p[11:2]] <= (mem1[mem_address_p[11:2]] & ~mem_mask_p) | (mem_w_p & mem_mask_p);
        end
        mem_v_p <= mem1[mem_address_p[11:2]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor for the round-robin instance.
    always @(negedge clk) begin
        if (i_rvalid) begin
            if (exp_i.size() == 0) chk("unexpected_i_rvalid", 1, 0);
            else chk("i_rdata", i_rdata, exp_i.pop_front());
        end
        if (d_rvalid) begin
            if (exp_d.size() == 0) chk("unexpected_d_rvalid", 1, 0);
            else chk("d_rdata", d_rdata, exp_d.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        i_addr = '0; d_addr = '0; d_mask = 32'hffffffff; d_wdata = 32'h5a5a5a5a;
        #2;
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_mem_wf", mem_wf, 0);
        chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(negedge clk);
        chk("rst_cnt_hold", conflict_cnt, 0);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // I-only read
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 12'h000;
        @(negedge clk);
        chk("t1_i_ready", i_ready, 1);
        chk("t1_d_ready", d_ready, 0);
        chk("t1_mem_addr", mem_address, 12'h000);
        chk("t1_mem_wf", mem_wf, 0);
        exp_i.push_back(32'hcafebabe);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        chk("t1_d_rvalid", d_rvalid, 0);

        // D write then D read of the same word
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h000;
        d_mask = 32'h0000ffff; d_wdata = 32'hdeadbeef;
        @(negedge clk);
        chk("t2_wr_d_ready", d_ready, 1);
        chk("t2_wr_mem_wf", mem_wf, 1);
        chk("t2_wr_mem_mask", mem_mask, 32'h0000ffff);
        chk("t2_wr_mem_w", mem_w, 32'hdeadbeef);
        @(posedge clk); #1;
        d_we = 1'b0;
        @(negedge clk);
        chk("t2_rd_d_ready", d_ready, 1);
        chk("t2_rd_mem_wf", mem_wf, 0);
        chk("t2_no_rvalid", {i_rvalid, d_rvalid}, 0);
        exp_d.push_back(32'hcafebeef);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("t2_i_rdata_hold", i_rdata, 32'hcafebabe);

        // Conflict: round-robin I,D,I,D vs fixed D priority
        @(posedge clk); #1;
        i_req = 1'b1; d_req = 1'b1; i_addr = 12'h004; d_addr = 12'h008;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_i_ready", i_ready, (k % 2 == 0));
            chk("rr_d_ready", d_ready, (k % 2 == 1));
            chk("pr_d_ready", d_ready_p, 1);
            chk("pr_i_ready", i_ready_p, 0);
            if (k % 2 == 0) exp_i.push_back(32'h11111111);
            else            exp_d.push_back(32'h22222222);
            @(posedge clk); #1;
        end
        d_req = 1'b0;
        @(negedge clk);
        chk("rr_cnt4", conflict_cnt, 4);
        chk("pr_cnt4", conflict_cnt_p, 4);
        chk("pr_i_after_d", i_ready_p, 1);
        chk("rr_i_alone", i_ready, 1);
        exp_i.push_back(32'h11111111);

        // 20 more conflict cycles: last grant was I, so D goes first
        @(posedge clk); #1;
        d_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("sat_d_ready", d_ready, (k % 2 == 0));
            chk("sat_i_ready", i_ready, (k % 2 == 1));
            chk("sat_pr_d_ready", d_ready_p, 1);
            if (k % 2 == 0) exp_d.push_back(32'h22222222);
            else            exp_i.push_back(32'h11111111);
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("rr_cnt24", conflict_cnt, 24);
        chk("pr_cnt_sat", conflict_cnt_p, 15);
        @(negedge clk);
        chk("pr_cnt_sat_hold", conflict_cnt_p, 15);

        // Reset while an I read of 0xff0 is in flight
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 12'hff0;
        @(negedge clk);
        chk("mr_i_ready", i_ready, 1);
        chk("mr_addr", mem_address, 12'hff0);
        @(posedge clk); #1;
        rst_n = 1'b0; d_req = 1'b1; d_we = 1'b1;
        #1;
        chk("mr_i_rvalid", i_rvalid, 0);
        chk("mr_i_rdata", i_rdata, 0);
        chk("mr_ready", {i_ready, d_ready}, 0);
        chk("mr_mem_wf", mem_wf, 0);
        chk("mr_cnt", conflict_cnt, 0);
        chk("mr_cnt_p", conflict_cnt_p, 0);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b1; d_req = 1'b1; i_addr = 12'h004; d_addr = 12'h008;
        @(negedge clk);
        chk("post_rst_tie_i", i_ready, 1);
        chk("post_rst_tie_d", d_ready, 0);
        chk("post_rst_pr_d", d_ready_p, 1);
        exp_i.push_back(32'h11111111);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_i_drained", exp_i.size(), 0);
        chk("sb_d_drained", exp_d.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
